// File: rtl/loop_ctrl_1_if.sv
// Loop controller bus: loop request/step inputs and pipeline status outputs.
// The controller itself takes the slave modport.
interface loop_ctrl_1_if #(
    parameter int width  = 4,
    parameter int stages = 3
);
    logic              start;
    logic [width-1:0]  trip;
    logic              step;
    logic              pred;
    logic [width-1:0]  lc;
    logic [stages-1:0] stage_en;
    logic              last;
    logic              busy;
    logic              done;

    modport master (
        output start, trip, step, pred,
        input  lc, stage_en, last, busy, done
    );

    modport slave (
        input  start, trip, step, pred,
        output lc, stage_en, last, busy, done
    );
endinterface

// File: rtl/loop_ctrl_1.sv
// Modulo-scheduled loop controller: counts iterations down and shifts a
// per-stage enable mask through the prologue, kernel and epilogue.
module loop_ctrl_1 #(
    parameter int width  = 4,
    parameter int stages = 3
) (
    input logic          clk,
    input logic          rst_n,
    loop_ctrl_1_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [width-1:0]  r_lc;
    logic [stages-1:0] r_stage_en;
    logic              r_done;

    logic              w_start;
    logic              w_go;
    logic [stages-1:0] w_shift;

    assign w_start = bus.start & bus.pred;
    assign w_go    = bus.step & bus.pred;
    // Shift expressed as << so stages=1 collapses cleanly to an all-zero mask.
    assign w_shift = r_stage_en << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lc       <= '0;
            r_stage_en <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (bus.trip != '0) begin
                            r_lc       <= bus.trip - 1'b1;
                            r_stage_en <= stages'(1);
                            r_state    <= RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_go) begin
                        if (r_lc != '0) begin
                            r_lc       <= r_lc - 1'b1;
                            r_stage_en <= w_shift | stages'(1);
                        end else begin
                            r_stage_en <= w_shift;
                            if (w_shift == '0) begin
                                r_state <= IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (w_go) begin
                        r_stage_en <= w_shift;
                        if (w_shift == '0) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_lc       <= '0;
                    r_stage_en <= '0;
                end
            endcase
        end
    end

    assign bus.lc       = r_lc;
    assign bus.stage_en = r_stage_en;
    assign bus.last     = (r_state == RUN) && (r_lc == '0);
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;

endmodule

// File: tb/tb_loop_ctrl_1.sv
// Scoreboard bench: two controllers (stages=3 and stages=1) share stimulus and
// are checked every cycle against an iteration-index model of the loop.
module tb_loop_ctrl_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st, sp, pr;
    logic [3:0] tr;

    always #5 clk = ~clk;

    loop_ctrl_1_if #(.width(4), .stages(3)) b3 ();
    loop_ctrl_1_if #(.width(4), .stages(1)) b1 ();

    assign b3.start = st;
    assign b3.trip  = tr;
    assign b3.step  = sp;
    assign b3.pred  = pr;
    assign b1.start = st;
    assign b1.trip  = tr;
    assign b1.step  = sp;
    assign b1.pred  = pr;

    loop_ctrl_1 #(.width(4), .stages(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    loop_ctrl_1 #(.width(4), .stages(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    typedef struct packed {
        logic [3:0] lc;
        logic [2:0] se;
        logic       busy;
        logic       last;
        logic       done;
    } exp_t;

    exp_t q3[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // Model: a loop is "k qualified steps since start" with trip count T.
    bit act[2];
    int T[2];
    int K[2];
    bit dn[2];
    int SS[2] = '{3, 1};

    function automatic exp_t mk(int d);
        exp_t e;
        e = '0;
        e.done = dn[d];
        if (act[d]) begin
            e.busy = 1'b1;
            for (int i = 0; i < SS[d]; i++)
                if (K[d] - i >= 0 && K[d] - i < T[d]) e.se[i] = 1'b1;
            e.lc   = (K[d] < T[d]) ? 4'(T[d] - 1 - K[d]) : 4'd0;
            e.last = (K[d] == T[d] - 1);
        end
        return e;
    endfunction

    task automatic model_step(int d, bit s, int t, bit g, bit p);
        dn[d] = 1'b0;
        if (!act[d]) begin
            if (s && p) begin
                if (t != 0) begin
                    act[d] = 1'b1;
                    T[d]   = t;
                    K[d]   = 0;
                end else begin
                    dn[d] = 1'b1;
                end
            end
        end else if (g && p) begin
            K[d]++;
            if (K[d] == T[d] + SS[d] - 1) begin
                act[d] = 1'b0;
                dn[d]  = 1'b1;
            end
        end
    endtask

    task automatic chk(string name, int act_v, int exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic tick(bit s, logic [3:0] t, bit g, bit p);
        @(negedge clk);
        st = s; tr = t; sp = g; pr = p;
        for (int d = 0; d < 2; d++) model_step(d, s, int'(t), g, p);
        q3.push_back(mk(0));
        q1.push_back(mk(1));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        st = 1'b0; sp = 1'b0; pr = 1'b0; tr = '0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_lc3",   int'(b3.lc), 0);
        chk("async_rst_se3",   int'(b3.stage_en), 0);
        chk("async_rst_busy3", int'(b3.busy), 0);
        chk("async_rst_last3", int'(b3.last), 0);
        chk("async_rst_done3", int'(b3.done), 0);
        chk("async_rst_busy1", int'(b1.busy), 0);
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0; dn[d] = 1'b0; K[d] = 0; T[d] = 0;
        end
        q3.push_back(mk(0));
        q1.push_back(mk(1));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle with a pending expectation, compare all outputs.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q3.size() > 0) begin
                e = q3.pop_front();
                a = '{lc: b3.lc, se: b3.stage_en, busy: b3.busy, last: b3.last, done: b3.done};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL s3_outputs: got lc=%0d se=%b busy=%b last=%b done=%b expected lc=%0d se=%b busy=%b last=%b done=%b at %0t",
                             a.lc, a.se, a.busy, a.last, a.done, e.lc, e.se, e.busy, e.last, e.done, $time);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = '{lc: b1.lc, se: {2'b00, b1.stage_en}, busy: b1.busy, last: b1.last, done: b1.done};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL s1_outputs: got lc=%0d se=%b busy=%b last=%b done=%b expected lc=%0d se=%b busy=%b last=%b done=%b at %0t",
                             a.lc, a.se, a.busy, a.last, a.done, e.lc, e.se, e.busy, e.last, e.done, $time);
                end
            end
        end
    end

    initial begin
        logic [2:0] se_seq [5];
        logic [3:0] lc_seq [5];
        int         qual;
        se_seq = '{3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
        lc_seq = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        rst_n = 1'b0;
        st = 1'b0; sp = 1'b0; pr = 1'b0; tr = '0;
        do_reset();

        // trip=3 with a step every cycle
        tick(1, 4'd3, 0, 1);
        chk("t3_start_se", int'(b3.stage_en), 1);
        chk("t3_start_lc", int'(b3.lc), 2);
        for (int i = 0; i < 5; i++) begin
            tick(0, 4'd0, 1, 1);
            chk($sformatf("t3_se_step%0d", i + 1), int'(b3.stage_en), int'(se_seq[i]));
            chk($sformatf("t3_lc_step%0d", i + 1), int'(b3.lc), int'(lc_seq[i]));
            chk($sformatf("t3_done_step%0d", i + 1), int'(b3.done), (i == 4) ? 1 : 0);
        end
        tick(0, 4'd0, 0, 1);
        chk("t3_done_clears", int'(b3.done), 0);

        // trip=0: no loop, immediate done
        tick(1, 4'd0, 0, 1);
        chk("t0_busy", int'(b3.busy), 0);
        chk("t0_done", int'(b3.done), 1);
        chk("t0_se",   int'(b3.stage_en), 0);
        tick(0, 4'd0, 0, 1);
        chk("t0_done_once", int'(b3.done), 0);

        // trip=2 with pred dropped on alternate cycles
        tick(1, 4'd2, 0, 1);
        qual = 0;
        for (int i = 0; i < 8; i++) begin
            tick(0, 4'd0, 1, (i % 2 == 1));
            if (i % 2 == 1) qual++;
            chk($sformatf("t2_pred_done%0d", i), int'(b3.done), (qual == 4 && i % 2 == 1) ? 1 : 0);
        end

        // start while busy is ignored
        tick(1, 4'd2, 0, 1);
        tick(1, 4'd7, 1, 1);
        chk("busy_start_lc", int'(b3.lc), 0);
        chk("busy_start_se", int'(b3.stage_en), 3);
        for (int i = 0; i < 3; i++) tick(0, 4'd0, 1, 1);
        chk("busy_start_done", int'(b3.done), 1);

        // stages=1 with trip=2 finishes straight from RUN
        tick(1, 4'd2, 0, 1);
        chk("s1_se0", int'(b1.stage_en), 1);
        tick(0, 4'd0, 1, 1);
        chk("s1_se1", int'(b1.stage_en), 1);
        chk("s1_lc1", int'(b1.lc), 0);
        tick(0, 4'd0, 1, 1);
        chk("s1_se2",  int'(b1.stage_en), 0);
        chk("s1_done", int'(b1.done), 1);
        chk("s1_idle", int'(b1.busy), 0);
        for (int i = 0; i < 3; i++) tick(0, 4'd0, 1, 1);

        // reset mid-RUN at lc=1, then a clean trip=1 loop
        tick(1, 4'd3, 0, 1);
        tick(0, 4'd0, 1, 1);
        chk("pre_rst_lc", int'(b3.lc), 1);
        do_reset();
        tick(1, 4'd1, 0, 1);
        chk("post_rst_se", int'(b3.stage_en), 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 4'd0, 1, 1);
            chk($sformatf("post_rst_done%0d", i + 1), int'(b3.done), (i == 2) ? 1 : 0);
        end

        // maximum trip count
        tick(1, 4'd15, 0, 1);
        chk("tmax_lc", int'(b3.lc), 14);
        for (int i = 0; i < 17; i++) tick(0, 4'd0, 1, 1);
        chk("tmax_done", int'(b3.done), 1);

        // randomized traffic, including starts in done cycles and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        tick(0, 4'd0, 0, 0);
        chk("queue_drained", q3.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/loop_ctrl_1.md
LOOP_CTRL_1 -- requirements
Module: loop_ctrl_1

Interface
REQ-001 SHALL have parameter width, default 4, giving the bit width of trip and lc.
REQ-002 SHALL have parameter stages, default 3, giving the pipeline stage count (legal range 1..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin a loop; qualified by pred.
REQ-006 SHALL have port trip, input, [width-1:0], iteration count, sampled with an accepted start.
REQ-007 SHALL have port step, input, 1, advance one initiation interval; qualified by pred.
REQ-008 SHALL have port pred, input, 1, guard predicate; when 0, start and step are ignored.
REQ-009 SHALL have port lc, output, [width-1:0], remaining iterations after the current one; drives downstream equality compare.
REQ-010 SHALL have port stage_en, output, [stages-1:0], per-stage enables; bit 0 is the first stage.
REQ-011 SHALL have port last, output, 1, which is 1 iff state is RUN and lc equals 0 (combinational from registers).
REQ-012 SHALL have port busy, output, 1, which is 1 iff state is not IDLE.
REQ-013 SHALL have port done, output, 1, a registered single-cycle completion pulse.

Function
REQ-014 SHALL implement the states IDLE, RUN and DRAIN.
REQ-015 In IDLE with start&pred=1 and trip!=0, SHALL next cycle set lc=trip-1, stage_en=1 (bit 0 only), state=RUN.
REQ-016 In IDLE with start&pred=1 and trip=0, SHALL stay IDLE, leave lc and stage_en at 0, and pulse done next cycle.
REQ-017 In RUN with step&pred=1 and lc!=0, SHALL decrement lc by 1 and shift stage_en left, inserting 1 at bit 0.
REQ-018 In RUN with step&pred=1 and lc=0, SHALL shift stage_en left inserting 0 and enter DRAIN; if the shifted value is all zero (stages=1), SHALL instead enter IDLE and pulse done.
REQ-019 In DRAIN with step&pred=1, SHALL shift stage_en left inserting 0; when the shifted value is all zero, SHALL enter IDLE and pulse done.
REQ-020 Steps from accepted start to done SHALL total trip+stages-1 for trip>=1.
REQ-021 SHALL hold all state unchanged in any cycle where step&pred=0 in RUN or DRAIN.
REQ-022 start SHALL be ignored while busy=1; start and step in the same IDLE cycle SHALL act as start only.
REQ-023 done SHALL be 1 for exactly one cycle and 0 otherwise; a start in the done cycle SHALL be accepted.
REQ-024 lc SHALL never wrap; it is not decremented below 0. trip=2^width-1 SHALL be legal.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, lc=0, stage_en=0 and done=0, giving busy=0 and last=0, regardless of the clock, including mid-loop.
REQ-026 After rst_n rises, the first accepted start SHALL behave per REQ-015/016, with no residual pipeline state.

Verification
REQ-027 Bench SHALL cover: trip=3, stages=3, step every cycle -> stage_en 001,011,111,110,100,000; lc 2,1,0; done on the 5th step's following cycle.
REQ-028 Bench SHALL cover: trip=0 start -> busy stays 0, done pulses once one cycle later, stage_en=0.
REQ-029 Bench SHALL cover: trip=2, step with pred=0 in alternate cycles -> state frozen on those cycles; 4 qualified steps to done.
REQ-030 Bench SHALL cover: start asserted while busy, trip=7 -> ignored; lc and stage_en are unaffected.
REQ-031 Bench SHALL cover: rst_n pulsed low mid-RUN at lc=1 -> outputs zero asynchronously; next start with trip=1 yields done after 3 steps.
REQ-032 Bench SHALL cover: stages=1, trip=2 -> stage_en 1,1,0, and done follows the 2nd step directly from RUN.
